hh_step_scheduler: RTL and testbench

- Time-multiplexes one shared Hodgkin-Huxley neuron-update datapath across NUM_NEURONS neuron contexts.
- Holds per-neuron state (membrane V and gates n, m, h) plus a per-neuron stimulus register.
- On each `tick`, issues every neuron to the datapath in index order, writes the results back, and publishes the timestep's spike vector.
- Sits between the tile's timestep generator and the single HH update datapath.

---
 rtl/hh_step_scheduler_if.sv | 36 +++
 rtl/hh_step_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_hh_step_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hh_step_scheduler_if.sv
// Request/response channel between hh_step_scheduler and the shared
// Hodgkin-Huxley update datapath.
//   master (scheduler): drives the request valid and payload, receives
//                       ready and the single-cycle response.
//   slave  (datapath) : the mirror image.
// Signals:
//   dp_req_valid / dp_req_ready        request handshake
//   dp_v, dp_n, dp_m, dp_h, dp_stim    request payload (one neuron context)
//   dp_rsp_valid                       response strobe, one cycle
//   dp_rsp_v, dp_rsp_n, dp_rsp_m, dp_rsp_h  updated neuron state
interface hh_step_scheduler_if #(
  parameter int W = 8
);
  logic         dp_req_valid;
  logic         dp_req_ready;
  logic [W-1:0] dp_v;
  logic [W-1:0] dp_n;
  logic [W-1:0] dp_m;
  logic [W-1:0] dp_h;
  logic [W-1:0] dp_stim;
  logic         dp_rsp_valid;
  logic [W-1:0] dp_rsp_v;
  logic [W-1:0] dp_rsp_n;
  logic [W-1:0] dp_rsp_m;
  logic [W-1:0] dp_rsp_h;

  modport master (
    output dp_req_valid, dp_v, dp_n, dp_m, dp_h, dp_stim,
    input  dp_req_ready, dp_rsp_valid, dp_rsp_v, dp_rsp_n, dp_rsp_m, dp_rsp_h
  );

  modport slave (
    input  dp_req_valid, dp_v, dp_n, dp_m, dp_h, dp_stim,
    output dp_req_ready, dp_rsp_valid, dp_rsp_v, dp_rsp_n, dp_rsp_m, dp_rsp_h
  );
endinterface

// File: rtl/hh_step_scheduler.sv
// Time-multiplexes one Hodgkin-Huxley update datapath over NUM_NEURONS
// neuron contexts. Each tick walks the contexts in index order (ISSUE ->
// WAIT -> WRITE per neuron), writes the datapath results back and then
// publishes the spike vector for that timestep.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   tick                start-of-timestep strobe
//   cfg_we/addr/data    per-neuron stimulus register write
//   overrun_clr         clears the sticky overrun and dp_error flags
//   dp                  datapath channel (hh_step_scheduler_if.master)
//   spikes              spike vector of the last completed timestep
//   step_done           one-cycle pulse when a timestep completes
//   busy                FSM is not idle
//   overrun             sticky: tick arrived while busy
//   dp_error            sticky: a datapath response timed out
module hh_step_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int W           = 8,
  parameter int THRESHOLD   = 150,
  parameter int TIMEOUT     = 15,
  parameter int N_INIT      = 8,
  parameter int M_INIT      = 2,
  parameter int H_INIT      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_addr,
  input  logic [W-1:0]           cfg_data,
  input  logic                   overrun_clr,
  hh_step_scheduler_if.master    dp,
  output logic [NUM_NEURONS-1:0] spikes,
  output logic                   step_done,
  output logic                   busy,
  output logic                   overrun,
  output logic                   dp_error
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

  state_t state_q, state_d;

  logic             hs;
  logic             rsp_take;
  logic             tmo_hit;
  logic             cfg_hit;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_nxt;
  logic [TMO_W-1:0] tmo_q;

  logic [W-1:0] ctx_v  [NUM_NEURONS];
  logic [W-1:0] ctx_n  [NUM_NEURONS];
  logic [W-1:0] ctx_m  [NUM_NEURONS];
  logic [W-1:0] ctx_h  [NUM_NEURONS];
  logic [W-1:0] stim_q [NUM_NEURONS];

  logic [W-1:0] pay_v_p0, pay_n_p0, pay_m_p0, pay_h_p0, pay_stim_p0;
  logic [W-1:0] rsp_v_p1, rsp_n_p1, rsp_m_p1, rsp_h_p1;
  logic         vld_p1;

  logic [NUM_NEURONS-1:0] spike_acc;

  // Unsigned threshold compare on the written-back membrane potential.
  function automatic logic crosses_threshold(input logic [W-1:0] v);
    return 32'(v) >= 32'(THRESHOLD);
  endfunction

  assign idx_nxt = idx_q + IDX_W'(1);
  assign cfg_hit = cfg_we && ({1'b0, cfg_addr} < 5'(NUM_NEURONS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    hs       = 1'b0;
    rsp_take = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      IDLE:  if (tick) state_d = ISSUE;
      ISSUE: if (dp.dp_req_ready) begin
        hs      = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // A response arriving on the last allowed cycle still wins.
        if (dp.dp_rsp_valid) begin
          rsp_take = 1'b1;
          state_d  = WRITE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: state_d = (idx_q == LAST_IDX) ? DONE : ISSUE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy            = (state_q != IDLE);
  assign dp.dp_req_valid = (state_q == ISSUE);
  assign dp.dp_v         = pay_v_p0;
  assign dp.dp_n         = pay_n_p0;
  assign dp.dp_m         = pay_m_p0;
  assign dp.dp_h         = pay_h_p0;
  assign dp.dp_stim      = pay_stim_p0;

  // Stimulus registers are independent of the step sequence; a write lands
  // next cycle and is seen the next time that neuron's payload is latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) stim_q[i] <= '0;
    end else if (cfg_hit) begin
      stim_q[cfg_addr[IDX_W-1:0]] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      tmo_q       <= '0;
      pay_v_p0    <= '0;
      pay_n_p0    <= '0;
      pay_m_p0    <= '0;
      pay_h_p0    <= '0;
      pay_stim_p0 <= '0;
      rsp_v_p1    <= '0;
      rsp_n_p1    <= '0;
      rsp_m_p1    <= '0;
      rsp_h_p1    <= '0;
      vld_p1      <= 1'b0;
      spike_acc   <= '0;
      spikes      <= '0;
      step_done   <= 1'b0;
      overrun     <= 1'b0;
      dp_error    <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        ctx_v[i] <= '0;
        ctx_n[i] <= W'(N_INIT);
        ctx_m[i] <= W'(M_INIT);
        ctx_h[i] <= W'(H_INIT);
      end
    end else begin
      step_done <= 1'b0;
      // Sticky flags: a set event in the clear cycle takes priority.
      overrun  <= (tick && busy) || (overrun && !overrun_clr);
      dp_error <= tmo_hit || (dp_error && !overrun_clr);

      case (state_q)
        // Stage p0: payload latched on entry to ISSUE, held until accepted.
        IDLE: if (tick) begin
          idx_q       <= '0;
          spike_acc   <= '0;
          pay_v_p0    <= ctx_v[0];
          pay_n_p0    <= ctx_n[0];
          pay_m_p0    <= ctx_m[0];
          pay_h_p0    <= ctx_h[0];
          pay_stim_p0 <= stim_q[0];
        end
        ISSUE: if (hs) tmo_q <= '0;
        // Stage p1: response capture, or abandonment on timeout.
        WAIT: begin
          if (rsp_take) begin
            rsp_v_p1 <= dp.dp_rsp_v;
            rsp_n_p1 <= dp.dp_rsp_n;
            rsp_m_p1 <= dp.dp_rsp_m;
            rsp_h_p1 <= dp.dp_rsp_h;
            vld_p1   <= 1'b1;
          end else if (tmo_hit) begin
            vld_p1 <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        // Stage p2: writeback and spike evaluation; a timed-out neuron keeps
        // its old context and never spikes.
        WRITE: begin
          if (vld_p1) begin
            ctx_v[idx_q]     <= rsp_v_p1;
            ctx_n[idx_q]     <= rsp_n_p1;
            ctx_m[idx_q]     <= rsp_m_p1;
            ctx_h[idx_q]     <= rsp_h_p1;
            spike_acc[idx_q] <= crosses_threshold(rsp_v_p1);
          end else begin
            spike_acc[idx_q] <= 1'b0;
          end
          if (idx_q != LAST_IDX) begin
            idx_q       <= idx_nxt;
            pay_v_p0    <= ctx_v[idx_nxt];
            pay_n_p0    <= ctx_n[idx_nxt];
            pay_m_p0    <= ctx_m[idx_nxt];
            pay_h_p0    <= ctx_h[idx_nxt];
            pay_stim_p0 <= stim_q[idx_nxt];
          end
        end
        DONE: begin
          spikes    <= spike_acc;
          step_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hh_step_scheduler.sv
module tb_hh_step_scheduler;
  localparam int NN  = 4;
  localparam int W   = 8;
  localparam int THR = 150;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_addr = '0;
  logic [W-1:0]  cfg_data = '0;
  logic          overrun_clr = 1'b0;
  logic [NN-1:0] spikes;
  logic          step_done, busy, overrun, dp_error;

  hh_step_scheduler_if #(.W(W)) dp();

  hh_step_scheduler #(
    .NUM_NEURONS(NN), .W(W), .THRESHOLD(THR), .TIMEOUT(TMO),
    .N_INIT(8), .M_INIT(2), .H_INIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .overrun_clr(overrun_clr), .dp(dp),
    .spikes(spikes), .step_done(step_done), .busy(busy),
    .overrun(overrun), .dp_error(dp_error)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Datapath behaviour per request slot of a step (set by the test).
  logic [31:0] rsp_tab   [NN];   // {v,n,m,h}
  int          stall_tab [NN];   // ready-low cycles before accepting
  int          delay_tab [NN];   // extra WAIT cycles before the response
  bit          drop_tab  [NN];   // never respond

  // What the datapath model observed.
  logic [39:0] log_req [NN];
  int          log_cnt;
  int          stall_seen;
  int          stall_bad;

  // Responder state.
  int          r_req_no, r_stalled, r_wait, r_k;
  bit          r_hs_prev, r_busy_prev;
  logic [39:0] r_pay, r_ref;

  // Reference model of neuron contexts.
  logic [W-1:0]  m_v [NN], m_n [NN], m_m [NN], m_h [NN], m_stim [NN];
  logic [39:0]   exp_req [NN];
  logic [NN-1:0] m_sp;
  int            m_lat;
  logic          m_err;

  typedef struct {
    logic          cfg_we;
    logic [3:0]    cfg_addr;
    logic [7:0]    cfg_data;
    int            stall_n;
    int            stall_len;
    int            drop_n;
    int            exp_lat;
    logic [NN-1:0] exp_spikes;
    logic          exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Datapath model: drives ready/response on the falling edge.
  initial begin : responder
    r_req_no = 0; r_stalled = 0; r_wait = -1; r_k = 0;
    r_hs_prev = 0; r_busy_prev = 0; log_cnt = 0; stall_seen = 0; stall_bad = 0;
    r_ref = '0;
    dp.dp_req_ready = 1'b1;
    dp.dp_rsp_valid = 1'b0;
    dp.dp_rsp_v = '0; dp.dp_rsp_n = '0; dp.dp_rsp_m = '0; dp.dp_rsp_h = '0;
    forever begin
      @(negedge clk);
      dp.dp_rsp_valid = 1'b0;
      if (busy && !r_busy_prev) begin
        r_req_no = 0; r_stalled = 0; r_hs_prev = 0;
        log_cnt = 0; stall_seen = 0; stall_bad = 0;
      end
      if (!busy) r_hs_prev = 0;
      r_busy_prev = busy;
      if (r_hs_prev) begin
        r_k = r_req_no;
        r_req_no++;
        r_wait = (r_k < NN && !drop_tab[r_k]) ? delay_tab[r_k] : -1;
        r_hs_prev = 0;
      end
      // A pending response is delivered even if the DUT was reset meanwhile.
      if (r_wait == 0) begin
        dp.dp_rsp_valid = 1'b1;
        {dp.dp_rsp_v, dp.dp_rsp_n, dp.dp_rsp_m, dp.dp_rsp_h} = rsp_tab[r_k];
        r_wait = -1;
      end else if (r_wait > 0) begin
        r_wait--;
      end
      if (dp.dp_req_valid) begin
        r_pay = {dp.dp_v, dp.dp_n, dp.dp_m, dp.dp_h, dp.dp_stim};
        if (r_req_no < NN && r_stalled < stall_tab[r_req_no]) begin
          if (r_stalled == 0) r_ref = r_pay;
          else if (r_pay !== r_ref) stall_bad++;
          r_stalled++;
          stall_seen++;
          dp.dp_req_ready = 1'b0;
        end else begin
          if (r_stalled > 0 && r_pay !== r_ref) stall_bad++;
          dp.dp_req_ready = 1'b1;
          if (r_req_no < NN) log_req[r_req_no] = r_pay;
          log_cnt++;
          r_hs_prev = 1;
          r_stalled = 0;
        end
      end else begin
        dp.dp_req_ready = 1'b1;
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NN; i++) begin
      m_v[i] = 8'd0; m_n[i] = 8'd8; m_m[i] = 8'd2; m_h[i] = 8'd4; m_stim[i] = 8'd0;
    end
  endtask

  task automatic zero_tables();
    for (int i = 0; i < NN; i++) begin
      stall_tab[i] = 0; delay_tab[i] = 0; drop_tab[i] = 0; rsp_tab[i] = '0;
    end
  endtask

  // Plan responses: V = 60,120,180,240 for neurons 0..3 (threshold falls
  // between neurons 1 and 2), gates incremented by one.
  task automatic set_plan_rsp();
    for (int i = 0; i < NN; i++)
      rsp_tab[i] = {8'((i + 1) * 60), m_n[i] + 8'd1, m_m[i] + 8'd1, m_h[i] + 8'd1};
  endtask

  // One timestep in the abstract: every neuron sends its context, takes the
  // response unless it was dropped, and spikes if the new V reaches THR.
  task automatic model_step();
    m_lat = 1;
    m_sp  = '0;
    m_err = 1'b0;
    for (int i = 0; i < NN; i++) begin
      exp_req[i] = {m_v[i], m_n[i], m_m[i], m_h[i], m_stim[i]};
      m_lat += 2 + stall_tab[i];
      if (drop_tab[i]) begin
        m_lat += TMO;
        m_err = 1'b1;
      end else begin
        m_lat += delay_tab[i] + 1;
        {m_v[i], m_n[i], m_m[i], m_h[i]} = rsp_tab[i];
        m_sp[i] = (int'(rsp_tab[i][31:24]) >= THR);
      end
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (int'(a) < NN) m_stim[a] = d;
  endtask

  task automatic clear_flags();
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
  endtask

  task automatic run_step(output int lat);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    lat = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (step_done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_step(input string tag, input int lat, input int exp_lat,
                            input logic [NN-1:0] exp_sp, input logic exp_err);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_spikes"}, 64'(spikes), 64'(exp_sp));
    check({tag, "_dp_error"}, 64'(dp_error), 64'(exp_err));
    check({tag, "_req_count"}, 64'(log_cnt), 64'(NN));
    for (int i = 0; i < NN; i++)
      check($sformatf("%s_req%0d", tag, i), 64'(log_req[i]), 64'(exp_req[i]));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int lat, pulses;
    // cfg_we, addr, data, stall_n, stall_len, drop_n, exp_lat, exp_spikes, exp_err
    vecs[0] = '{1'b0, 4'd0, 8'h00, -1, 0, -1, 13, 4'b1100, 1'b0};
    vecs[1] = '{1'b1, 4'd2, 8'h40, -1, 0, -1, 13, 4'b1100, 1'b0};
    vecs[2] = '{1'b1, 4'd9, 8'h77, -1, 0, -1, 13, 4'b1100, 1'b0};
    vecs[3] = '{1'b0, 4'd0, 8'h00,  1, 5, -1, 18, 4'b1100, 1'b0};
    vecs[4] = '{1'b0, 4'd0, 8'h00, -1, 0,  3, 27, 4'b0100, 1'b1};
    vecs[5] = '{1'b0, 4'd0, 8'h00, -1, 0, -1, 13, 4'b1100, 1'b0};

    zero_tables();
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_spikes", 64'(spikes), 64'(0));
    check("reset_step_done", 64'(step_done), 64'(0));
    check("reset_overrun", 64'(overrun), 64'(0));
    check("reset_dp_error", 64'(dp_error), 64'(0));
    check("reset_req_valid", 64'(dp.dp_req_valid), 64'(0));
    check("reset_payload", 64'({dp.dp_v, dp.dp_n, dp.dp_m, dp.dp_h, dp.dp_stim}), 64'(0));
    rst_n = 1'b1;

    // Directed vectors with plan responses.
    for (int v = 0; v < 6; v++) begin
      zero_tables();
      if (vecs[v].stall_n >= 0) stall_tab[vecs[v].stall_n] = vecs[v].stall_len;
      if (vecs[v].drop_n >= 0) drop_tab[vecs[v].drop_n] = 1'b1;
      if (vecs[v].cfg_we) cfg_write(vecs[v].cfg_addr, vecs[v].cfg_data);
      set_plan_rsp();
      model_step();
      run_step(lat);
      check_step($sformatf("vec%0d", v), lat, vecs[v].exp_lat, vecs[v].exp_spikes, vecs[v].exp_err);
      if (vecs[v].stall_len > 0) begin
        check($sformatf("vec%0d_stall_cycles", v), 64'(stall_seen), 64'(vecs[v].stall_len));
        check($sformatf("vec%0d_stall_stable", v), 64'(stall_bad), 64'(0));
      end
      clear_flags();
      #1;
      check($sformatf("vec%0d_flags_cleared", v), 64'({overrun, dp_error}), 64'(0));
    end

    // Second tick four cycles into a step: one step only, overrun set.
    zero_tables(); set_plan_rsp(); model_step();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (step_done) pulses++;
    end
    check("ovr_done_pulses", 64'(pulses), 64'(1));
    check("ovr_overrun", 64'(overrun), 64'(1));
    check("ovr_spikes", 64'(spikes), 64'(m_sp));
    check("ovr_req_count", 64'(log_cnt), 64'(NN));
    check("ovr_busy", 64'(busy), 64'(0));

    // Tick landing in the DONE cycle is an overrun and starts nothing.
    clear_flags();
    zero_tables(); set_plan_rsp(); model_step();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (12) @(negedge clk);
    tick = 1'b1;
    @(posedge clk); #1;
    check("done_tick_step_done", 64'(step_done), 64'(1));
    check("done_tick_overrun", 64'(overrun), 64'(1));
    check("done_tick_spikes", 64'(spikes), 64'(m_sp));
    @(negedge clk); tick = 1'b0;
    @(posedge clk); #1;
    check("done_tick_busy", 64'(busy), 64'(0));
    check("done_tick_pulse_len", 64'(step_done), 64'(0));

    // Reset while waiting on neuron 2, with a late response after reset.
    clear_flags();
    zero_tables(); delay_tab[2] = 4; set_plan_rsp();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_mid_busy_before", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_spikes", 64'(spikes), 64'(0));
    check("rst_mid_step_done", 64'(step_done), 64'(0));
    check("rst_mid_flags", 64'({overrun, dp_error}), 64'(0));
    check("rst_mid_req_valid", 64'(dp.dp_req_valid), 64'(0));
    check("rst_mid_payload", 64'({dp.dp_v, dp.dp_n, dp.dp_m, dp.dp_h, dp.dp_stim}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("late_rsp_busy", 64'(busy), 64'(0));
    check("late_rsp_spikes", 64'(spikes), 64'(0));
    model_reset();
    zero_tables(); set_plan_rsp(); model_step();
    run_step(lat);
    check_step("post_reset", lat, m_lat, m_sp, m_err);

    // Randomized steps against the reference model.
    for (int s = 0; s < 20; s++) begin
      int nw;
      clear_flags();
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++)
        cfg_write(4'($urandom_range(0, 15)), 8'($urandom));
      for (int i = 0; i < NN; i++) begin
        rsp_tab[i]   = $urandom;
        stall_tab[i] = $urandom_range(0, 3);
        delay_tab[i] = $urandom_range(0, 4);
        drop_tab[i]  = ($urandom_range(0, 7) == 0);
      end
      model_step();
      run_step(lat);
      check_step($sformatf("rnd%0d", s), lat, m_lat, m_sp, m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
